// File: rtl/register_unmapper_if.sv
// Bundle of the rename-map control, translate and physical-swap handshake signals.
// Latency: none, wires only.
// Backpressure: swap_valid/swap_a/swap_b are held by the slave until the master returns swap_ack.
interface register_unmapper_if;
  logic [1:0] reg1;
  logic [1:0] reg2;
  logic       doSWAP;
  logic [1:0] phys_q;
  logic       restore_req;
  logic       swap_ack;
  logic [1:0] logical_q;
  logic       swap_valid;
  logic [1:0] swap_a;
  logic [1:0] swap_b;
  logic       busy;
  logic       restore_done;
  logic       map_is_identity;

  modport master (
    output reg1, reg2, doSWAP, phys_q, restore_req, swap_ack,
    input  logical_q, swap_valid, swap_a, swap_b, busy, restore_done, map_is_identity
  );

  modport slave (
    input  reg1, reg2, doSWAP, phys_q, restore_req, swap_ack,
    output logical_q, swap_valid, swap_a, swap_b, busy, restore_done, map_is_identity
  );
endinterface

// File: rtl/register_unmapper.sv
// Logical->physical register map updated by SWAP renames, plus a sequencer that restores identity via physical data swaps.
// Latency: logical_q/map_is_identity combinational from the registered map; renames and accepted swaps land on the next edge.
// Backpressure: each physical swap request is held on swap_valid/a/b until swap_ack; doSWAP/restore_req are dropped outside IDLE.
module register_unmapper (
  input logic                clk,
  input logic                reset,
  register_unmapper_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SCAN, SWAP, DONE} state_t;

  localparam logic [3:0][1:0] IDENT = {2'd3, 2'd2, 2'd1, 2'd0};

  state_t          state;
  logic [1:0]      idx;
  logic [3:0][1:0] map;   // map[logical] = physical
  logic [3:0][1:0] inv;   // inv[physical] = logical
  logic            swap_valid_q;
  logic [1:0]      swap_a_q;
  logic [1:0]      swap_b_q;
  logic            busy_q;
  logic            done_q;

  // Invert the permutation held in map.
  always_comb begin
    inv = '0;
    for (int i = 0; i < 4; i++) begin
      inv[map[i]] = 2'(i);
    end
  end

  assign bus.logical_q       = inv[bus.phys_q];
  assign bus.map_is_identity = (map == IDENT);
  assign bus.swap_valid      = swap_valid_q;
  assign bus.swap_a          = swap_a_q;
  assign bus.swap_b          = swap_b_q;
  assign bus.busy            = busy_q;
  assign bus.restore_done    = done_q;

  // Map updates and restore sequencer; outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      map          <= IDENT;
      state        <= IDLE;
      idx          <= '0;
      swap_valid_q <= 1'b0;
      swap_a_q     <= '0;
      swap_b_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A rename in the same cycle as restore_req lands first, so the scan sees it.
          if (bus.doSWAP && (bus.reg1 != bus.reg2)) begin
            map[bus.reg1] <= map[bus.reg2];
            map[bus.reg2] <= map[bus.reg1];
          end
          if (bus.restore_req) begin
            state  <= SCAN;
            idx    <= '0;
            busy_q <= 1'b1;
          end
        end
        SCAN: begin
          if (map[idx] != idx) begin
            state        <= SWAP;
            swap_valid_q <= 1'b1;
            swap_a_q     <= idx;
            swap_b_q     <= map[idx];
          end else if (idx == 2'd3) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            idx <= idx + 2'd1;
          end
        end
        SWAP: begin
          // After the data swap, logical idx lives in physical idx and the logical
          // that lived in physical idx moves to idx's old physical slot.
          if (bus.swap_ack) begin
            map[inv[idx]] <= map[idx];
            map[idx]      <= idx;
            state         <= SCAN;
            swap_valid_q  <= 1'b0;
            swap_a_q      <= '0;
            swap_b_q      <= '0;
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_register_unmapper.sv
// Bench for register_unmapper: directed scenarios, a behavioural model checked every cycle, literal pins.
// Latency: inputs driven 1ns after posedge, outputs compared on negedge.
// Backpressure: an ack responder returns swap_ack a programmable number of cycles after swap_valid.
module tb_register_unmapper;
  logic clk = 1'b0;
  logic reset;
  register_unmapper_if bus ();

  register_unmapper dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // m_loc[l] = physical slot holding logical l's data. A restore walks the
  // slots in order; whenever a slot holds the wrong logical it requests a
  // data exchange with the slot where the right logical currently lives.
  int m_loc [4];
  int m_phase;   // 0 idle, 1 scanning, 2 waiting for ack, 3 finishing
  int m_pos;
  bit chk_en = 1'b0;

  always @(posedge clk) begin : model
    int nl [4];
    int nphase, npos, tmp, holder;
    for (int i = 0; i < 4; i++) nl[i] = m_loc[i];
    nphase = m_phase;
    npos   = m_pos;
    if (reset) begin
      for (int i = 0; i < 4; i++) nl[i] = i;
      nphase = 0;
      npos   = 0;
    end else if (m_phase == 0) begin
      if (bus.doSWAP) begin
        tmp = nl[bus.reg1]; nl[bus.reg1] = nl[bus.reg2]; nl[bus.reg2] = tmp;
      end
      if (bus.restore_req) begin nphase = 1; npos = 0; end
    end else if (m_phase == 1) begin
      if (m_loc[m_pos] != m_pos) nphase = 2;
      else if (m_pos == 3) nphase = 3;
      else npos = m_pos + 1;
    end else if (m_phase == 2) begin
      if (bus.swap_ack) begin
        holder = 0;
        for (int l = 0; l < 4; l++) if (m_loc[l] == m_pos) holder = l;
        nl[holder] = m_loc[m_pos];
        nl[m_pos]  = m_pos;
        nphase = 1;
      end
    end else begin
      nphase = 0;
    end
    for (int i = 0; i < 4; i++) m_loc[i] <= nl[i];
    m_phase <= nphase;
    m_pos   <= npos;
  end

  function automatic int model_logical(input int p);
    int r = 0;
    for (int l = 0; l < 4; l++) if (m_loc[l] == p) r = l;
    return r;
  endfunction

  function automatic int model_ident();
    int r = 1;
    for (int l = 0; l < 4; l++) if (m_loc[l] != l) r = 0;
    return r;
  endfunction

  // Compare process: every output against the model on every cycle after the first reset.
  always @(negedge clk) begin
    if (chk_en) begin
      check("logical_q", int'(bus.logical_q), model_logical(int'(bus.phys_q)));
      check("map_is_identity", int'(bus.map_is_identity), model_ident());
      check("swap_valid", int'(bus.swap_valid), int'(m_phase == 2));
      check("swap_a", int'(bus.swap_a), (m_phase == 2) ? m_pos : 0);
      check("swap_b", int'(bus.swap_b), (m_phase == 2) ? m_loc[m_pos] : 0);
      check("busy", int'(bus.busy), int'(m_phase == 1 || m_phase == 2));
      check("restore_done", int'(bus.restore_done), int'(m_phase == 3));
    end
  end

  // Accepted swaps, recorded for literal comparison.
  int acc_a [$];
  int acc_b [$];
  always @(negedge clk) begin
    if (chk_en && bus.swap_valid && bus.swap_ack) begin
      acc_a.push_back(int'(bus.swap_a));
      acc_b.push_back(int'(bus.swap_b));
    end
  end

  // ---------------- ack responder ----------------
  bit ack_en    = 1'b0;
  int ack_delay = 0;
  initial begin : acker
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (ack_en) begin
        if (bus.swap_valid) begin
          cnt++;
          bus.swap_ack = (cnt > ack_delay);
        end else begin
          cnt = 0;
          bus.swap_ack = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); reset = 1'b0;
  endtask

  task automatic do_swap(input int a, input int b);
    bus.reg1 = 2'(a); bus.reg2 = 2'(b); bus.doSWAP = 1'b1;
    tick();
    bus.doSWAP = 1'b0;
  endtask

  task automatic pulse_restore();
    bus.restore_req = 1'b1; tick(); bus.restore_req = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.restore_done) seen = 1'b1;
    end
    check({name, "_done_seen"}, int'(seen), 1);
    tick();
  endtask

  task automatic wait_swap_valid(input string name, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.swap_valid) seen = 1'b1;
    end
    check({name, "_swap_valid_seen"}, int'(seen), 1);
    tick();
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int busy_cycles;
    bit saw_valid;
    reset = 1'b1;
    bus.reg1 = '0; bus.reg2 = '0; bus.doSWAP = 1'b0; bus.phys_q = '0;
    bus.restore_req = 1'b0; bus.swap_ack = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk_en = 1'b1;

    // Reset state and identity translation.
    @(negedge clk);
    check("rst_swap_valid", int'(bus.swap_valid), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.restore_done), 0);
    check("rst_ident", int'(bus.map_is_identity), 1);
    for (int p = 0; p < 4; p++) begin
      tick(); bus.phys_q = 2'(p);
      @(negedge clk);
      check("rst_logical_q", int'(bus.logical_q), p);
    end
    tick();

    // Single rename (0,2).
    do_swap(0, 2);
    bus.phys_q = 2'd2; @(negedge clk);
    check("ren02_p2", int'(bus.logical_q), 0);
    check("ren02_ident", int'(bus.map_is_identity), 0);
    tick(); bus.phys_q = 2'd0; @(negedge clk);
    check("ren02_p0", int'(bus.logical_q), 2);
    tick();
    do_swap(1, 1);
    @(negedge clk);
    check("ren11_noop", int'(bus.logical_q), 2);
    tick();

    // Identity restore: 4 busy cycles, one done pulse, no swaps.
    do_reset();
    pulse_restore();
    busy_cycles = 0; saw_valid = 1'b0;
    for (int i = 0; i < 20 && busy_cycles >= 0; i++) begin
      @(negedge clk);
      if (bus.swap_valid) saw_valid = 1'b1;
      if (bus.busy) busy_cycles++;
      else if (busy_cycles > 0) begin
        check("id_done_after_busy", int'(bus.restore_done), 1);
        i = 20;
      end
    end
    check("id_busy_cycles", busy_cycles, 4);
    check("id_no_swap", int'(saw_valid), 0);
    tick();

    // Two renames then restore with delayed acks: swaps (0,1) then (1,3).
    ack_en = 1'b1; ack_delay = 2;
    do_swap(0, 1);
    do_swap(1, 3);
    acc_a.delete(); acc_b.delete();
    pulse_restore();
    wait_done("r24", 60);
    check("r24_nswaps", acc_a.size(), 2);
    if (acc_a.size() == 2) begin
      check("r24_a0", acc_a[0], 0); check("r24_b0", acc_b[0], 1);
      check("r24_a1", acc_a[1], 1); check("r24_b1", acc_b[1], 3);
    end
    @(negedge clk);
    check("r24_ident", int'(bus.map_is_identity), 1);
    tick();

    // Renames and restore_req during SWAP are ignored; ack in first SWAP cycle accepted.
    ack_delay = 50;
    do_swap(0, 3);
    acc_a.delete(); acc_b.delete();
    pulse_restore();
    wait_swap_valid("r25", 10);
    do_swap(2, 3);
    pulse_restore();
    bus.phys_q = 2'd2; @(negedge clk);
    check("r25_p2_held", int'(bus.logical_q), 2);
    check("r25_b_held", int'(bus.swap_b), 3);
    tick();
    ack_delay = 0;
    wait_done("r25", 60);
    check("r25_nswaps", acc_a.size(), 1);
    @(negedge clk);
    check("r25_ident", int'(bus.map_is_identity), 1);
    tick();

    // swap_ack outside SWAP is ignored.
    ack_en = 1'b0;
    do_swap(1, 2);
    bus.swap_ack = 1'b1; tick(); tick(); bus.swap_ack = 1'b0;
    @(negedge clk);
    check("ack_idle_ident", int'(bus.map_is_identity), 0);
    tick();

    // Reset mid-SWAP: request drops without ack, no done pulse.
    ack_en = 1'b1; ack_delay = 50;
    pulse_restore();
    wait_swap_valid("r26", 10);
    reset = 1'b1; tick(); reset = 1'b0;
    @(negedge clk);
    check("r26_valid", int'(bus.swap_valid), 0);
    check("r26_busy", int'(bus.busy), 0);
    check("r26_ident", int'(bus.map_is_identity), 1);
    check("r26_done", int'(bus.restore_done), 0);
    repeat (5) tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
